// File: rtl/lightgun_port_if.sv
// Signal bundle between the light gun emulator/VDP side and the lightgun_port stage.
// Optional trigger debounce is selected in the design by LIGHTGUN_TRIG_DEBOUNCE_EN.
interface lightgun_port_if;
    logic       CE_PIX;
    logic       GUN_EN;
    logic       SENSOR;
    logic       TRIGGER;
    logic       TH_DIR;
    logic       TH_OUT;
    logic [8:0] HCOUNT;
    logic       FRAME;
    logic       TL_N;
    logic       TH_N;
    logic [7:0] HLATCH;
    logic       LATCHED;
    logic       LATCH_STB;

    modport master (
        output CE_PIX, GUN_EN, SENSOR, TRIGGER, TH_DIR, TH_OUT, HCOUNT, FRAME,
        input  TL_N, TH_N, HLATCH, LATCHED, LATCH_STB
    );

    modport slave (
        input  CE_PIX, GUN_EN, SENSOR, TRIGGER, TH_DIR, TH_OUT, HCOUNT, FRAME,
        output TL_N, TH_N, HLATCH, LATCHED, LATCH_STB
    );
endinterface

// File: rtl/lightgun_port.sv
// Controller-port TH/TL pins for the light gun, with once-per-frame H-counter latch.
// Define LIGHTGUN_TRIG_DEBOUNCE_EN to add a DEBOUNCE_LEN-cycle trigger debouncer.
module lightgun_port #(
    parameter logic [8:0]  LATCH_OFFSET = 9'd0,
    parameter logic [15:0] DEBOUNCE_LEN = 16'd1024
) (
    input logic           CLK,
    input logic           RESET,
    lightgun_port_if.slave gun
);
    typedef enum logic [1:0] {IDLE, ARMED, HELD} state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic       r_sensor;
    logic       r_trig;
    logic       r_th_n;
    logic       r_tl_n;
    logic [8:0] r_hcnt_hold;
    logic [7:0] r_hlatch;
    logic       r_latched;
    logic       r_latch_stb;
    logic       w_th_eff;
    logic       w_edge;
    logic       w_trig_clean;
    logic [8:0] w_hcnt;
    logic [8:0] w_hsum;
    logic       w_do_latch;
    logic       w_latched_next;

    assign w_th_eff = gun.TH_DIR ? ~(r_sensor & gun.GUN_EN) : gun.TH_OUT;
    assign w_edge   = r_th_n & ~w_th_eff;
    assign w_hcnt   = gun.CE_PIX ? gun.HCOUNT : r_hcnt_hold;
    assign w_hsum   = w_hcnt + LATCH_OFFSET;

`ifdef LIGHTGUN_TRIG_DEBOUNCE_EN
    logic        r_trig_clean;
    logic [15:0] r_db_cnt;

    // Counter only runs while the raw level disagrees with the clean level.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_trig_clean <= 1'b0;
            r_db_cnt     <= 16'd0;
        end else if (r_trig == r_trig_clean) begin
            r_db_cnt <= 16'd0;
        end else if (r_db_cnt == DEBOUNCE_LEN - 16'd1) begin
            r_trig_clean <= r_trig;
            r_db_cnt     <= 16'd0;
        end else begin
            r_db_cnt <= r_db_cnt + 16'd1;
        end
    end

    assign w_trig_clean = r_trig_clean;
`else
    logic [15:0] w_unused_debounce_len;

    assign w_unused_debounce_len = DEBOUNCE_LEN;
    assign w_trig_clean          = r_trig;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= IDLE;
            r_sensor    <= 1'b0;
            r_trig      <= 1'b0;
            r_th_n      <= 1'b1;
            r_tl_n      <= 1'b1;
            r_hcnt_hold <= 9'd0;
            r_hlatch    <= 8'h00;
            r_latched   <= 1'b0;
            r_latch_stb <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_sensor    <= gun.SENSOR;
            r_trig      <= gun.TRIGGER;
            r_th_n      <= w_th_eff;
            r_tl_n      <= ~(w_trig_clean & gun.GUN_EN);
            r_latched   <= w_latched_next;
            r_latch_stb <= w_do_latch;
            if (gun.CE_PIX) begin
                r_hcnt_hold <= gun.HCOUNT;
            end
            if (w_do_latch) begin
                r_hlatch <= w_hsum[8:1];
            end
        end
    end

    // A frame boundary is handled before an edge arriving in the same cycle.
    always_comb begin
        w_state_next   = r_state;
        w_do_latch     = 1'b0;
        w_latched_next = r_latched;
        case (r_state)
            IDLE: begin
                if (gun.FRAME) begin
                    w_state_next = ARMED;
                end
            end
            ARMED: begin
                if (w_edge) begin
                    w_do_latch     = 1'b1;
                    w_latched_next = 1'b1;
                    w_state_next   = HELD;
                end
            end
            HELD: begin
                if (gun.FRAME) begin
                    if (w_edge) begin
                        w_do_latch     = 1'b1;
                        w_latched_next = 1'b1;
                    end else begin
                        w_latched_next = 1'b0;
                        w_state_next   = ARMED;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign gun.TL_N      = r_tl_n;
    assign gun.TH_N      = r_th_n;
    assign gun.HLATCH    = r_hlatch;
    assign gun.LATCHED   = r_latched;
    assign gun.LATCH_STB = r_latch_stb;
endmodule

// File: tb/tb_lightgun_port.sv
// Directed bench for lightgun_port: latch scoreboard, frame rule, software path, trigger timing.
// A second instance with LATCH_OFFSET=20 covers the 9-bit wrap of the latch sum.
module tb_lightgun_port;
    logic clk;
    logic rst;
    int   asserts = 0;
    int   fails   = 0;
    int   stbCount = 0;
    int   expCount = 0;
    logic prevStb = 1'b0;
    logic [7:0] expQ[$];

    lightgun_port_if gif ();
    lightgun_port_if gifB ();

    assign gifB.CE_PIX  = gif.CE_PIX;
    assign gifB.GUN_EN  = gif.GUN_EN;
    assign gifB.SENSOR  = gif.SENSOR;
    assign gifB.TRIGGER = gif.TRIGGER;
    assign gifB.TH_DIR  = gif.TH_DIR;
    assign gifB.TH_OUT  = gif.TH_OUT;
    assign gifB.HCOUNT  = gif.HCOUNT;
    assign gifB.FRAME   = gif.FRAME;

    lightgun_port #(.LATCH_OFFSET(9'd0), .DEBOUNCE_LEN(16'd16)) dutA (
        .CLK   (clk),
        .RESET (rst),
        .gun   (gif.slave)
    );

    lightgun_port #(.LATCH_OFFSET(9'd20), .DEBOUNCE_LEN(16'd16)) dutB (
        .CLK   (clk),
        .RESET (rst),
        .gun   (gifB.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] latchVal(input logic [8:0] hc, input logic [8:0] off);
        logic [8:0] s;
        s = hc + off;
        return s[8:1];
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        asserts++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulseFrame();
        gif.FRAME = 1'b1;
        tick(1);
        gif.FRAME = 1'b0;
    endtask

    // Sensor pulse: the edge is seen one clock after SENSOR rises, latch one clock later.
    task automatic applyStimulus(input logic [8:0] hc, input bit expectLatch);
        gif.HCOUNT = hc;
        gif.SENSOR = 1'b1;
        if (expectLatch) begin
            expQ.push_back(latchVal(hc, 9'd0));
            expCount++;
        end
        tick(2);
        checkOutput("thFollowsSensor", 16'(gif.TH_N), 16'd0);
        gif.SENSOR = 1'b0;
        tick(3);
    endtask

    always @(negedge clk) begin
        if (gif.LATCH_STB === 1'b1) begin
            stbCount++;
            checkOutput("stbWidth", 16'(prevStb), 16'd0);
            if (expQ.size() == 0) begin
                checkOutput("unexpectedStb", 16'd1, 16'd0);
            end else begin
                checkOutput("hlatchAtStb", 16'(gif.HLATCH), 16'(expQ.pop_front()));
            end
        end
        prevStb = gif.LATCH_STB;
    end

    initial begin
        rst         = 1'b1;
        gif.CE_PIX  = 1'b1;
        gif.GUN_EN  = 1'b1;
        gif.SENSOR  = 1'b0;
        gif.TRIGGER = 1'b0;
        gif.TH_DIR  = 1'b1;
        gif.TH_OUT  = 1'b1;
        gif.HCOUNT  = 9'd0;
        gif.FRAME   = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);
        checkOutput("rstTlN", 16'(gif.TL_N), 16'd1);
        checkOutput("rstThN", 16'(gif.TH_N), 16'd1);
        checkOutput("rstHlatch", 16'(gif.HLATCH), 16'd0);
        checkOutput("rstLatched", 16'(gif.LATCHED), 16'd0);
        checkOutput("rstStb", 16'(gif.LATCH_STB), 16'd0);

        applyStimulus(9'd100, 1'b0);
        checkOutput("noLatchBeforeFrame", 16'(gif.LATCHED), 16'd0);

        pulseFrame();
        applyStimulus(9'd200, 1'b1);
        checkOutput("latch200", 16'(gif.HLATCH), 16'd100);
        checkOutput("latched200", 16'(gif.LATCHED), 16'd1);
        checkOutput("latch200Offset", 16'(gifB.HLATCH), 16'(latchVal(9'd200, 9'd20)));

        applyStimulus(9'd300, 1'b0);
        checkOutput("oncePerFrame", 16'(gif.HLATCH), 16'd100);

        pulseFrame();
        checkOutput("frameClearsLatched", 16'(gif.LATCHED), 16'd0);
        applyStimulus(9'd40, 1'b1);
        checkOutput("latch40", 16'(gif.HLATCH), 16'd20);

        pulseFrame();
        applyStimulus(9'd500, 1'b1);
        checkOutput("wrapOffset", 16'(gifB.HLATCH), 16'd4);
        checkOutput("noWrapNoOffset", 16'(gif.HLATCH), 16'd250);

        // FRAME coincides with the edge cycle while HELD.
        gif.HCOUNT = 9'd60;
        gif.SENSOR = 1'b1;
        expQ.push_back(latchVal(9'd60, 9'd0));
        expCount++;
        tick(1);
        gif.FRAME = 1'b1;
        tick(1);
        gif.FRAME = 1'b0;
        checkOutput("simulLatched", 16'(gif.LATCHED), 16'd1);
        checkOutput("simulHlatch", 16'(gif.HLATCH), 16'd30);
        gif.SENSOR = 1'b0;
        tick(3);
        applyStimulus(9'd80, 1'b0);
        checkOutput("simulStaysHeld", 16'(gif.HLATCH), 16'd30);

        gif.GUN_EN  = 1'b0;
        gif.TRIGGER = 1'b1;
        gif.SENSOR  = 1'b1;
        tick(3);
        checkOutput("gunOffTl", 16'(gif.TL_N), 16'd1);
        checkOutput("gunOffTh", 16'(gif.TH_N), 16'd1);
        pulseFrame();
        gif.TH_DIR = 1'b0;
        gif.TH_OUT = 1'b1;
        tick(2);
        gif.HCOUNT = 9'd150;
        gif.TH_OUT = 1'b0;
        expQ.push_back(latchVal(9'd150, 9'd0));
        expCount++;
        tick(1);
        checkOutput("swLatch", 16'(gif.HLATCH), 16'd75);
        checkOutput("swLatched", 16'(gif.LATCHED), 16'd1);
        checkOutput("swThN", 16'(gif.TH_N), 16'd0);
        gif.TH_OUT  = 1'b1;
        gif.TH_DIR  = 1'b1;
        gif.GUN_EN  = 1'b1;
        gif.TRIGGER = 1'b0;
        gif.SENSOR  = 1'b0;
        tick(4);

        // Edge cycle with CE_PIX low uses the last enabled HCOUNT sample.
        pulseFrame();
        gif.HCOUNT = 9'd100;
        tick(1);
        gif.CE_PIX = 1'b0;
        gif.HCOUNT = 9'd400;
        gif.SENSOR = 1'b1;
        expQ.push_back(8'd50);
        expCount++;
        tick(2);
        checkOutput("cePixHold", 16'(gif.HLATCH), 16'd50);
        gif.CE_PIX = 1'b1;
        gif.SENSOR = 1'b0;
        tick(3);

`ifdef LIGHTGUN_TRIG_DEBOUNCE_EN
        gif.TRIGGER = 1'b1;
        tick(10);
        gif.TRIGGER = 1'b0;
        tick(2);
        checkOutput("bounceIgnored", 16'(gif.TL_N), 16'd1);
        gif.TRIGGER = 1'b1;
        tick(17);
        checkOutput("debounceEarly", 16'(gif.TL_N), 16'd1);
        tick(1);
        checkOutput("debounceFall", 16'(gif.TL_N), 16'd0);
        gif.TRIGGER = 1'b0;
        tick(20);
`else
        gif.TRIGGER = 1'b1;
        tick(1);
        checkOutput("trigEarly", 16'(gif.TL_N), 16'd1);
        tick(1);
        checkOutput("trigFall", 16'(gif.TL_N), 16'd0);
        gif.TRIGGER = 1'b0;
        tick(2);
        checkOutput("trigRise", 16'(gif.TL_N), 16'd1);
`endif

        // Reset while HELD with an edge pending, then an edge before any FRAME.
        gif.TRIGGER = 1'b1;
        gif.SENSOR  = 1'b1;
        rst = 1'b1;
        tick(3);
        checkOutput("midRstTlN", 16'(gif.TL_N), 16'd1);
        checkOutput("midRstThN", 16'(gif.TH_N), 16'd1);
        checkOutput("midRstHlatch", 16'(gif.HLATCH), 16'd0);
        checkOutput("midRstLatched", 16'(gif.LATCHED), 16'd0);
        rst = 1'b0;
        gif.TRIGGER = 1'b0;
        tick(4);
        checkOutput("postRstNoLatch", 16'(gif.LATCHED), 16'd0);
        gif.SENSOR = 1'b0;
        tick(3);

        checkOutput("stbCount", 16'(stbCount), 16'(expCount));
        checkOutput("queueDrained", 16'(expQ.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule

// File: doc/lightgun_port.md
# lightgun_port

Controller-port stage downstream of the light gun emulator. Turns the gun's `SENSOR` and `TRIGGER` into the active-low TH/TL port pins. Implements the VDP horizontal-counter latch that fires on a TH falling edge, with the SMS rule of at most one latch per frame. Its outputs feed the I/O port read mux (`$DC`/`$DD`) and the H-counter read register (`$7F`).

## Interface
Parameters:
- `LATCH_OFFSET`, default 9'd0: pipeline compensation added to `HCOUNT` before latching.
- `DEBOUNCE_LEN`, default 16'd1024: trigger debounce length in `CLK` cycles (used only with the debounce macro).

Ports:
- `CLK` in 1: system clock. One clock domain.
- `RESET` in 1: synchronous, active-high reset.
- `CE_PIX` in 1: pixel clock enable.
- `GUN_EN` in 1: gun is plugged into the port.
- `SENSOR` in 1: light detected, active high.
- `TRIGGER` in 1: trigger pressed, active high.
- `TH_DIR` in 1: I/O control TH direction. 1 = input (gun drives TH); 0 = output (CPU drives TH).
- `TH_OUT` in 1: CPU-written TH level, used when `TH_DIR`=0.
- `HCOUNT` in 9: VDP horizontal pixel counter.
- `FRAME` in 1: single-cycle pulse at the start of vertical blank.
- `TL_N` out 1: port TL pin, 0 = trigger pressed.
- `TH_N` out 1: effective port TH pin level.
- `HLATCH` out 8: latched H counter value.
- `LATCHED` out 1: a latch has occurred this frame.
- `LATCH_STB` out 1: single-cycle pulse when `HLATCH` updates.

## Operation
- Reset values: `TL_N`=1, `TH_N`=1, `HLATCH`=8'h00, `LATCHED`=0, `LATCH_STB`=0. FSM enters `IDLE`. The debounce counter is cleared.
- `sensor_r` is `SENSOR` registered once. `th_eff` is `TH_DIR ? ~(sensor_r & GUN_EN) : TH_OUT`. `TH_N` is `th_eff`, registered.
- `TL_N` = `~(trig_clean & GUN_EN)`, registered.
- An edge is detected when the previous `TH_N` is 1 and the next `th_eff` is 0. Edge detection runs every `CLK` and does not depend on `CE_PIX`.
- FSM states:
  - `IDLE`: after reset, latching is blocked. On `FRAME`, go to `ARMED`.
  - `ARMED`: on an edge, latch, pulse `LATCH_STB`, set `LATCHED`=1, go to `HELD`.
  - `HELD`: further edges are ignored. On `FRAME`, clear `LATCHED` and go to `ARMED`. `HLATCH` keeps its value.
- `FRAME` and an edge in the same cycle, in `ARMED` or `HELD`: treat the frame boundary first, then the edge. Result: latch happens, `LATCHED`=1, state is `HELD`.
- `FRAME` and an edge in the same cycle, in `IDLE`: go to `ARMED` only; no latch.
- Latch arithmetic: `hsum` = `HCOUNT + LATCH_OFFSET`, 9-bit, wraps mod 512. `HLATCH` = `hsum[8:1]`.
- Software latch: when `TH_DIR`=0, a CPU 1→0 write on `TH_OUT` latches through the same FSM path. `GUN_EN` does not gate this path.
- `GUN_EN`=0: sensor and trigger are masked, so `TL_N`=1. `TH_N`=1 whenever `TH_DIR`=1.
- `RESET` asserted during `HELD`: next cycle is `IDLE` with all outputs at reset values. A pending edge is discarded.

## Timing
- `SENSOR` → `TH_N`: 2 `CLK` (input register + output register).
- Latch: `HLATCH` and `LATCH_STB` appear 1 `CLK` after the cycle in which the edge is detected. `HCOUNT` is sampled in the edge-detect cycle.
- `TRIGGER` → `TL_N`: 2 `CLK` without debounce. With debounce, see Configuration.
- `LATCH_STB` is high for exactly 1 `CLK`. At most one pulse per frame.
- `CE_PIX` is used only to qualify the `HCOUNT` sample. If `CE_PIX`=0 in the edge cycle, the last `HCOUNT` sampled while `CE_PIX`=1 is used.

## Configuration
- `LIGHTGUN_TRIG_DEBOUNCE_EN` defined:
  - `trig_clean` changes only after the registered `TRIGGER` has differed from `trig_clean` for `DEBOUNCE_LEN` consecutive `CLK`.
  - The counter restarts on any bounce back to the current `trig_clean` level.
  - `TRIGGER` → `TL_N` latency is `DEBOUNCE_LEN`+2 `CLK`.
- Undefined: `trig_clean` is the registered `TRIGGER`. No counter is synthesized.

## Test plan
- Reset: hold `RESET` 3 cycles mid-`HELD` → all outputs at reset values; an edge before the first `FRAME` produces no `LATCH_STB`.
- Latch: `GUN_EN`=1, `TH_DIR`=1, `FRAME` pulse, `SENSOR` rises with `HCOUNT`=9'd200, `LATCH_OFFSET`=0 → `HLATCH`=8'd100, one `LATCH_STB`, `LATCHED`=1.
- Once per frame: a second `SENSOR` pulse at `HCOUNT`=9'd300 in the same frame → `HLATCH` stays 100 with no strobe. After the next `FRAME` plus a pulse at `HCOUNT`=9'd40 → `HLATCH`=8'd20.
- Wrap: `LATCH_OFFSET`=9'd20, `HCOUNT`=9'd500 → `hsum`=8, `HLATCH`=8'd4.
- Simultaneous and software paths:
  - `FRAME` and edge in the same cycle while `HELD` → latch occurs, `LATCHED` stays 1.
  - `TH_DIR`=0, `TH_OUT` 1→0 with `GUN_EN`=0 → latch occurs.
- Debounce (macro defined, `DEBOUNCE_LEN`=16):
  - `TRIGGER` high for 10 cycles, low for 2, high for 16 → `TL_N` falls 18 cycles after the final rise.
  - Macro undefined → `TL_N` falls 2 cycles after the first rise.
